// File: rtl/mac_if.sv
// Window-in / result-out bundle for the 3x3 convolution MAC.
// The producer side (window generator) is the master; the MAC is the slave.
interface mac_if;
  logic       i_inhibit;
  logic       i_valid;
  logic [8:0] i_q;
  logic [8:0] zero_vector;
  logic [7:0] i_im1, i_im2, i_im3, i_im4, i_im5, i_im6, i_im7, i_im8, i_im9;
  logic [3:0] i_ker1, i_ker2, i_ker3, i_ker4, i_ker5, i_ker6, i_ker7, i_ker8, i_ker9;
  logic       o_valid;
  logic [15:0] o_conv;

  modport master (
    output i_inhibit, i_valid, i_q, zero_vector,
    output i_im1, i_im2, i_im3, i_im4, i_im5, i_im6, i_im7, i_im8, i_im9,
    output i_ker1, i_ker2, i_ker3, i_ker4, i_ker5, i_ker6, i_ker7, i_ker8, i_ker9,
    input  o_valid, o_conv
  );

  modport slave (
    input  i_inhibit, i_valid, i_q, zero_vector,
    input  i_im1, i_im2, i_im3, i_im4, i_im5, i_im6, i_im7, i_im8, i_im9,
    input  i_ker1, i_ker2, i_ker3, i_ker4, i_ker5, i_ker6, i_ker7, i_ker8, i_ker9,
    output o_valid, o_conv
  );
endinterface

// File: rtl/mac.sv
// 9-tap multiply-accumulate: unsigned pixels x sign-magnitude weights plus signed bias,
// three register stages (products, row sums, total -> sign-magnitude), one window per clock.
module mac (
  input  logic clk,
  input  logic i_rst_n,   // active-high synchronous reset despite the name
  mac_if.slave bus
);
  localparam int TAPS = 9;

  logic [7:0] im  [TAPS];
  logic [3:0] ker [TAPS];

  assign im[0] = bus.i_im1;  assign ker[0] = bus.i_ker1;
  assign im[1] = bus.i_im2;  assign ker[1] = bus.i_ker2;
  assign im[2] = bus.i_im3;  assign ker[2] = bus.i_ker3;
  assign im[3] = bus.i_im4;  assign ker[3] = bus.i_ker4;
  assign im[4] = bus.i_im5;  assign ker[4] = bus.i_ker5;
  assign im[5] = bus.i_im6;  assign ker[5] = bus.i_ker6;
  assign im[6] = bus.i_im7;  assign ker[6] = bus.i_ker7;
  assign im[7] = bus.i_im8;  assign ker[7] = bus.i_ker8;
  assign im[8] = bus.i_im9;  assign ker[8] = bus.i_ker9;

  logic acc;
  assign acc = bus.i_valid & ~bus.i_inhibit;

  logic [10:0] prod [TAPS];

  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      prod[k] = bus.zero_vector[k] ? 11'd0 : 11'(im[k]) * 11'(ker[k][2:0]);
    end
  end

  // Stage 1: unsigned products with a sign flag that is never set on a zero product.
  logic              v1;
  logic [8:0]        q1;
  logic [10:0]       p1 [TAPS];
  logic [TAPS-1:0]   s1;

  always_ff @(posedge clk) begin
    if (i_rst_n) begin
      v1 <= 1'b0;
      q1 <= '0;
      s1 <= '0;
      // NOTE: the product array is cleared like any other register; reset must flush
      // everything in flight, so this storage is not left to hold stale data.
      for (int k = 0; k < TAPS; k++) p1[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every stage reading the previous cycle's values.
      v1 <= acc;
      q1 <= bus.i_q;
      for (int k = 0; k < TAPS; k++) begin
        p1[k] <= prod[k];
        s1[k] <= ker[k][3] & (prod[k] != 11'd0);
      end
    end
  end

  // Stage 2: signed row sums; 14 bits covers the worst row of +/-5355.
  logic signed [13:0] term [TAPS];

  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      term[k] = s1[k] ? -$signed({3'b000, p1[k]}) : $signed({3'b000, p1[k]});
    end
  end

  logic               v2;
  logic [8:0]         q2;
  logic signed [13:0] row [3];

  always_ff @(posedge clk) begin
    if (i_rst_n) begin
      v2 <= 1'b0;
      q2 <= '0;
      for (int j = 0; j < 3; j++) row[j] <= '0;
    end else begin
      v2 <= v1;
      q2 <= q1;
      for (int j = 0; j < 3; j++) row[j] <= term[3*j] + term[3*j+1] + term[3*j+2];
    end
  end

  // Stage 3: 17-bit two's-complement total, then sign-magnitude with saturation.
  logic [16:0] total;
  logic [16:0] mag;
  logic [15:0] conv_next;

  always_comb begin
    total = {{3{row[0][13]}}, row[0]} + {{3{row[1][13]}}, row[1]}
          + {{3{row[2][13]}}, row[2]} + {{8{q2[8]}}, q2};
    mag   = total[16] ? (~total + 17'd1) : total;
    conv_next = {total[16], (mag > 17'h07FFF) ? 15'h7FFF : mag[14:0]};
  end

  always_ff @(posedge clk) begin
    if (i_rst_n) begin
      bus.o_valid <= 1'b0;
      bus.o_conv  <= '0;
    end else begin
      bus.o_valid <= v2;
      if (v2) bus.o_conv <= conv_next;
    end
  end
endmodule

// File: tb/tb_mac.sv
// Self-checking bench for mac: directed spec vectors plus randomized streams
// compared against an integer-arithmetic reference of the convolution.
module tb_mac;
  logic clk = 1'b0;
  logic i_rst_n;
  mac_if bus ();

  mac dut (.clk(clk), .i_rst_n(i_rst_n), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  tim  [9];
  logic [3:0]  tker [9];
  logic [15:0] exp_q [$];

  initial begin
    #400000;
    $display("FAIL watchdog expired: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic apply(input logic valid, input logic inhibit,
                       input logic [8:0] zv, input logic [8:0] q);
    bus.i_valid = valid;  bus.i_inhibit = inhibit;
    bus.zero_vector = zv; bus.i_q = q;
    bus.i_im1 = tim[0]; bus.i_im2 = tim[1]; bus.i_im3 = tim[2];
    bus.i_im4 = tim[3]; bus.i_im5 = tim[4]; bus.i_im6 = tim[5];
    bus.i_im7 = tim[6]; bus.i_im8 = tim[7]; bus.i_im9 = tim[8];
    bus.i_ker1 = tker[0]; bus.i_ker2 = tker[1]; bus.i_ker3 = tker[2];
    bus.i_ker4 = tker[3]; bus.i_ker5 = tker[4]; bus.i_ker6 = tker[5];
    bus.i_ker7 = tker[6]; bus.i_ker8 = tker[7]; bus.i_ker9 = tker[8];
  endtask

  task automatic random_window();
    for (int k = 0; k < 9; k++) begin
      tim[k]  = 8'($urandom);
      tker[k] = 4'($urandom);
    end
  endtask

  // Reference: plain integer convolution, then sign-magnitude with saturation.
  function automatic logic [15:0] model(input logic [8:0] zv, input logic [8:0] q);
    int   sum;
    int   p;
    logic neg;
    sum = int'($signed(q));
    for (int k = 0; k < 9; k++) begin
      p = zv[k] ? 0 : int'(tim[k]) * int'(tker[k][2:0]);
      sum += tker[k][3] ? -p : p;
    end
    neg = (sum < 0);
    if (neg) sum = -sum;
    if (sum > 32767) sum = 32767;
    return {neg, sum[14:0]};
  endfunction

  // Drives one valid window at a negedge with an empty pipeline; returns what is seen
  // on the two cycles before the result is due and on the cycle it is due.
  task automatic send(input logic [8:0] zv, input logic [8:0] q,
                      output logic early, output logic valid, output logic [15:0] conv);
    apply(1'b1, 1'b0, zv, q);
    @(negedge clk);
    early = bus.o_valid;
    apply(1'b0, 1'b0, zv, q);
    @(negedge clk);
    early = early | bus.o_valid;
    @(negedge clk);
    valid = bus.o_valid;
    conv  = bus.o_conv;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b1;
    for (int k = 0; k < 9; k++) begin tim[k] = '0; tker[k] = '0; end
    apply(1'b0, 1'b0, 9'h0, 9'h0);
    repeat (2) @(negedge clk);
    checks++;
    if (bus.o_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b want 0", bus.o_valid);
    end
    checks++;
    if (bus.o_conv !== 16'h0000) begin
      errors++; $display("FAIL reset_conv got %h want 0000", bus.o_conv);
    end
    i_rst_n = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [8:0]  zv, q;
    logic [15:0] exp_v, conv;
    logic        early, valid;
    for (int c = 0; c < 9; c++) begin
      zv = 9'h0; q = 9'd0;
      for (int k = 0; k < 9; k++) begin tim[k] = 8'hFF; tker[k] = 4'h7; end
      case (c)
        0: exp_v = 16'h3EC1;
        1: begin q = 9'd17; exp_v = 16'h3ED2; end
        2: begin q = 9'd17; for (int k = 0; k < 9; k++) tker[k] = 4'hF; exp_v = 16'hBEB0; end
        3: begin for (int k = 0; k < 9; k++) tker[k] = 4'hF; exp_v = 16'hBEC1; end
        4: begin random_window(); zv = 9'h1FF; q = 9'd17; exp_v = 16'h0011; end
        5: begin random_window(); for (int k = 0; k < 9; k++) tker[k] = 4'h8; exp_v = 16'h0000; end
        6: begin
             for (int k = 0; k < 9; k++) begin tim[k] = 8'(10 * (k + 1)); tker[k] = 4'h0; end
             tker[0] = 4'h1; q = 9'd17; exp_v = 16'h001B;
           end
        7: begin
             for (int k = 0; k < 9; k++) begin tim[k] = 8'(10 * (k + 1)); tker[k] = 4'h0; end
             tker[8] = 4'hB; exp_v = 16'h810E;
           end
        default: begin for (int k = 0; k < 9; k++) tker[k] = 4'h0; q = 9'h1FB; exp_v = 16'h8005; end
      endcase
      send(zv, q, early, valid, conv);
      checks++;
      if ({early, valid} !== 2'b01) begin
        errors++;
        $display("FAIL directed%0d_timing got early=%b valid=%b want early=0 valid=1", c, early, valid);
      end
      checks++;
      if (conv !== exp_v) begin
        errors++; $display("FAIL directed%0d_conv got %h want %h", c, conv, exp_v);
      end
      @(negedge clk);
      checks++;
      if (bus.o_valid !== 1'b0 || bus.o_conv !== exp_v) begin
        errors++;
        $display("FAIL directed%0d_hold got valid=%b conv=%h want valid=0 conv=%h",
                 c, bus.o_valid, bus.o_conv, exp_v);
      end
    end
  endtask

  // Runs a stream of cycles; mode 0 = all valid, 1 = all valid with 5 inhibits, 2 = random mix.
  task automatic run_stream(input int mode, input int ncyc, output int nout, output int first,
                            output int gaps, output int accepted);
    logic [8:0]  zv, q;
    logic [15:0] e;
    logic        v, inh;
    int          last;
    nout = 0; first = -1; gaps = 0; accepted = 0; last = -1;
    exp_q.delete();
    for (int c = 0; c < ncyc + 20; c++) begin
      if (bus.o_valid === 1'b1) begin
        nout++;
        if (first < 0) first = c;
        if (last >= 0 && last != c - 1) gaps++;
        last = c;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stream%0d_extra unexpected result %h at cycle %0d", mode, bus.o_conv, c);
        end else begin
          e = exp_q.pop_front();
          if (bus.o_conv !== e) begin
            errors++; $display("FAIL stream%0d_data cycle %0d got %h want %h", mode, c, bus.o_conv, e);
          end
        end
      end
      if (c < ncyc) begin
        random_window();
        zv = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'h0;
        q  = 9'($urandom);
        case (mode)
          0: begin v = 1'b1; inh = 1'b0; end
          1: begin v = 1'b1; inh = (c == 5 || c == 17 || c == 18 || c == 64 || c == 127); end
          default: begin v = ($urandom_range(0, 1) == 1); inh = ($urandom_range(0, 3) == 0); end
        endcase
        apply(v, inh, zv, q);
        if (v && !inh) begin
          exp_q.push_back(model(zv, q));
          accepted++;
        end
      end else begin
        apply(1'b0, 1'b0, 9'h0, 9'h0);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int nout, first, gaps, accepted;
    run_stream(0, 128, nout, first, gaps, accepted);
    checks++;
    if (nout !== 128) begin errors++; $display("FAIL b2b_count got %0d want 128", nout); end
    checks++;
    if (first !== 3) begin errors++; $display("FAIL b2b_first got cycle %0d want 3", first); end
    checks++;
    if (gaps !== 0) begin errors++; $display("FAIL b2b_gaps got %0d want 0", gaps); end
  endtask

  task automatic test_inhibit();
    int nout, first, gaps, accepted;
    run_stream(1, 128, nout, first, gaps, accepted);
    checks++;
    if (nout !== 123) begin errors++; $display("FAIL inhibit_count got %0d want 123", nout); end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL inhibit_pending got %0d missing results want 0", exp_q.size());
    end
  endtask

  task automatic test_mixed();
    int nout, first, gaps, accepted;
    run_stream(2, 200, nout, first, gaps, accepted);
    checks++;
    if (nout !== accepted) begin
      errors++; $display("FAIL mixed_count got %0d want %0d", nout, accepted);
    end
  endtask

  task automatic test_reset_in_flight();
    logic [15:0] e, conv;
    logic        early, valid;
    int          stray;
    random_window(); apply(1'b1, 1'b0, 9'h0, 9'd17);
    @(negedge clk);
    random_window(); apply(1'b1, 1'b0, 9'h0, 9'd3);
    @(negedge clk);
    apply(1'b0, 1'b0, 9'h0, 9'h0);
    i_rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL flight_reset_valid got %b want 0", bus.o_valid); end
    checks++;
    if (bus.o_conv !== 16'h0000) begin errors++; $display("FAIL flight_reset_conv got %h want 0000", bus.o_conv); end
    i_rst_n = 1'b0;
    stray = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.o_valid === 1'b1) stray++;
    end
    checks++;
    if (stray !== 0) begin errors++; $display("FAIL flight_dropped got %0d stray results want 0", stray); end
    random_window();
    e = model(9'h0, 9'd17);
    send(9'h0, 9'd17, early, valid, conv);
    checks++;
    if ({early, valid} !== 2'b01) begin
      errors++; $display("FAIL flight_new_timing got early=%b valid=%b want early=0 valid=1", early, valid);
    end
    checks++;
    if (conv !== e) begin errors++; $display("FAIL flight_new_conv got %h want %h", conv, e); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_inhibit();
    test_mixed();
    test_reset_in_flight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
